td4_core_param: RTL
===================

Name: td4_core_param

Overview:
Parametrised successor to the 4-bit TD4 CPU core. It is a single-cycle accumulator machine with registers A and B, a carry flag, a program counter, an input port and an output latch. The core fetches from an asynchronous program memory on the A/D bus and keeps TD4 opcode compatibility at default parameters. It adds generic data and address widths, a HALT instruction, a clock-enable/single-step input and a status output. It replaces the fixed TD4 core under the same program-memory model.

Parameters:
DATA_W, 4, width of A, B, IN, OUT, immediate field (4..16)
ADDR_W, 4, program counter / address bus width; must be <= DATA_W

Ports:
CLK  input  1  clock, all state updates on rising edge
CLR  input  1  reset, asynchronous, active-low
EN  input  1  execute enable; low = hold all state (single-step when pulsed)
A  output  ADDR_W  instruction address (= PC)
D  input  4+DATA_W  instruction word: D[DATA_W+3:DATA_W]=opcode, D[DATA_W-1:0]=Im
IN  input  DATA_W  input port, sampled at execute edge
OUT  output  DATA_W  output latch
CARRY  output  1  carry flag
HALTED  output  1  core halted

Behaviour:
- Reset: CLR low clears A, B, OUT, PC, C and HALTED to 0 immediately, independent of CLK. These values are held while CLR is low. The first execute is on the first rising edge after CLR goes high.
- Fetch is combinational: A = PC, and D must be valid within the same cycle. Each instruction executes on one rising edge with EN=1 and HALTED=0. Latency is 1 cycle per instruction.
- EN=0 or HALTED=1: no register, flag, PC or OUT change.
- All arithmetic is modulo 2^DATA_W. Carry = bit DATA_W of the (DATA_W+1)-bit sum.
- Opcodes (Im = immediate), with the effect at the execute edge:
  0000 ADD A,Im: A<=A+Im, C<=carry
  0101 ADD B,Im: B<=B+Im, C<=carry
  0011 MOV A,Im: A<=Im
  0111 MOV B,Im: B<=Im
  0001 MOV A,B: A<=B
  0100 MOV B,A: B<=A
  0010 IN A: A<=IN
  0110 IN B: B<=IN
  1001 OUT B: OUT<=B
  1011 OUT Im: OUT<=Im
  1111 JMP Im: PC<=Im[ADDR_W-1:0]
  1110 JNC Im: if C==0, PC<=Im[ADDR_W-1:0], otherwise PC+1
  1000 HLT: HALTED<=1, PC not incremented, C unchanged
  all other opcodes: NOP
- PC: every non-jump, non-HLT instruction sets PC<=PC+1. It wraps from 2^ADDR_W-1 to 0.
- Carry: every executed instruction except ADD and HLT sets C<=0, as in TD4. JNC tests the C value from before the edge.
- Im bits above ADDR_W are ignored by jumps.
- HALTED stays 1 until CLR is asserted. EN has no effect while halted.
- CLR asserted mid-cycle aborts the current instruction; no partial update survives.

Test Plan:
- Defaults with program 0:IN A(0x20), 1:MOV B,A(0x40), 2:OUT B(0x90), 3:JMP 0(0xF0) and IN=0xD. After 3 edges OUT=0xD; after the 4th A=0. Set IN=0x7; after 3 more edges OUT=0x7.
- Defaults with MOV A,0xE; ADD A,3; JNC 0; MOV B,1. After ADD: A=1, CARRY=1. JNC is not taken, so A(addr)=3. After MOV B: CARRY=0, B=1.
- HLT at address 5: after its edge HALTED=1 and A stays 5 for 10 cycles with OUT unchanged. CLR low clears HALTED and A to 0.
- Hold EN low for 3 edges mid-program: A, OUT, CARRY and HALTED are unchanged. One-cycle EN pulses advance exactly one instruction each.
- DATA_W=8, ADDR_W=6:
  - MOV A,0x02; ADD A,0xFF gives A=0x01, CARRY=1.
  - JMP 0xAA gives A=0x2A.
  - A NOP stream from 0x3F wraps to 0x00.
- Drive CLR low between clock edges mid-program: OUT, A, CARRY and HALTED go to 0 before the next edge. Execution restarts at address 0.

Source files
------------

// File: rtl/td4_core_param.sv
// Parametrised TD4-compatible single-cycle accumulator core with HALT, execute enable
// and a halted status output. Program memory is asynchronous and addressed by A (= PC).
module td4_core_param #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              EN,
    output logic [ADDR_W-1:0] A,
    input  logic [DATA_W+3:0] D,
    input  logic [DATA_W-1:0] IN,
    output logic [DATA_W-1:0] OUT,
    output logic              CARRY,
    output logic              HALTED
);

    if (DATA_W < 4 || DATA_W > 16) begin : g_bad_data_w
        $error("td4_core_param: DATA_W must be in 4..16");
    end
    if (ADDR_W > DATA_W) begin : g_bad_addr_w
        $error("td4_core_param: ADDR_W must not exceed DATA_W");
    end

    typedef enum logic [3:0] {
        OpAddA   = 4'b0000,
        OpMovAB  = 4'b0001,
        OpInA    = 4'b0010,
        OpMovAIm = 4'b0011,
        OpMovBA  = 4'b0100,
        OpAddB   = 4'b0101,
        OpInB    = 4'b0110,
        OpMovBIm = 4'b0111,
        OpHlt    = 4'b1000,
        OpOutB   = 4'b1001,
        OpOutIm  = 4'b1011,
        OpJnc    = 4'b1110,
        OpJmp    = 4'b1111
    } opcode_e;

    logic [DATA_W-1:0] reg_a_q, reg_a_d;
    logic [DATA_W-1:0] reg_b_q, reg_b_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              c_q, c_d;
    logic              halted_q, halted_d;

    opcode_e           opcode;
    logic [DATA_W-1:0] im;
    logic [ADDR_W-1:0] im_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic [DATA_W:0]   sum_a;
    logic [DATA_W:0]   sum_b;

    assign opcode  = opcode_e'(D[DATA_W+3:DATA_W]);
    assign im      = D[DATA_W-1:0];
    assign im_addr = im[ADDR_W-1:0];
    assign pc_inc  = pc_q + 1'b1;
    assign sum_a   = {1'b0, reg_a_q} + {1'b0, im};
    assign sum_b   = {1'b0, reg_b_q} + {1'b0, im};

    always_comb begin
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        out_d    = out_q;
        pc_d     = pc_q;
        c_d      = c_q;
        halted_d = halted_q;
        if (EN && !halted_q) begin
            // Everything but ADD and HLT clears carry, as on the original TD4.
            c_d  = 1'b0;
            pc_d = pc_inc;
            case (opcode)
                OpAddA: begin
                    reg_a_d = sum_a[DATA_W-1:0];
                    c_d     = sum_a[DATA_W];
                end
                OpAddB: begin
                    reg_b_d = sum_b[DATA_W-1:0];
                    c_d     = sum_b[DATA_W];
                end
                OpMovAIm: reg_a_d = im;
                OpMovBIm: reg_b_d = im;
                OpMovAB:  reg_a_d = reg_b_q;
                OpMovBA:  reg_b_d = reg_a_q;
                OpInA:    reg_a_d = IN;
                OpInB:    reg_b_d = IN;
                OpOutB:   out_d   = reg_b_q;
                OpOutIm:  out_d   = im;
                OpJmp:    pc_d    = im_addr;
                OpJnc: begin
                    if (!c_q) pc_d = im_addr;
                end
                OpHlt: begin
                    halted_d = 1'b1;
                    pc_d     = pc_q;
                    c_d      = c_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            out_q    <= '0;
            pc_q     <= '0;
            c_q      <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            out_q    <= out_d;
            pc_q     <= pc_d;
            c_q      <= c_d;
            halted_q <= halted_d;
        end
    end

    assign A      = pc_q;
    assign OUT    = out_q;
    assign CARRY  = c_q;
    assign HALTED = halted_q;

endmodule
